sync_fifo_ctrl: RTL and testbench

Parametrised synchronous FIFO: the successor to the fixed 8-bit FIFO, with configurable data width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between a producer and a consumer in the same clock domain, for example as the RX/TX buffer of the UART path and the command queues of the presentation design.

---
 rtl/sync_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Parametrised synchronous FIFO with show-ahead read, occupancy count,
// almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_ctrl #(
    parameter int DEPTH     = 4,
    parameter int BIT_WIDTH = 8,
    parameter int AF_LEVEL  = DEPTH - 1,
    parameter int AE_LEVEL  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic [BIT_WIDTH-1:0]       push_data,
    output logic [BIT_WIDTH-1:0]       pop_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wptr_reg, wptr_next;
    logic [PTR_W-1:0] rptr_reg, rptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic full_flag;
    logic empty_flag;
    logic push_acc;
    logic pop_acc;
    logic wr_en;

    // Flags come only from the registered count, never from push/pop.
    assign full_flag  = (count_reg == DEPTH_CNT);
    assign empty_flag = (count_reg == '0);

    assign push_acc = push & ~full_flag;
    assign pop_acc  = pop & ~empty_flag;
    assign wr_en    = push_acc & ~flush;

    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        // Clear first so that a same-cycle error below wins.
        if (clr_err) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end

        if (flush) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end else begin
            if (push_acc) begin
                wptr_next = wptr_reg + PTR_W'(1);
            end
            if (pop_acc) begin
                rptr_next = rptr_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(push_acc) - CNT_W'(pop_acc);
            if (push && full_flag) begin
                overflow_next = 1'b1;
            end
            if (pop && empty_flag) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is never reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wptr_reg] <= push_data;
        end
    end

    assign pop_data     = mem[rptr_reg];
    assign full         = full_flag;
    assign empty        = empty_flag;
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: stimulus queues expected words, a
// negedge monitor checks pop_data whenever the DUT presents a word being popped.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int BW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [BW-1:0] push_data = '0;
    logic [BW-1:0] pop_data;
    logic          full, empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    logic [BW-1:0] exp_q [$];

    sync_fifo_ctrl #(
        .DEPTH(DEPTH), .BIT_WIDTH(BW), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .clr_err(clr_err), .push_data(push_data), .pop_data(pop_data),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Monitor: the consumer samples pop_data in the cycle it asserts pop.
    always @(negedge clk) begin
        if (!rst && !flush && pop && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data unexpected word actual=%h required=none", pop_data);
            end else begin
                logic [BW-1:0] e;
                e = exp_q.pop_front();
                if (pop_data !== e) begin
                    errors++;
                    $display("FAIL pop_data actual=%h required=%h", pop_data, e);
                end else begin
                    $display("pop  data=%h ok", pop_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic [BW-1:0] d, input logic q,
                       input logic f = 1'b0, input logic c = 1'b0);
        int pa, qa;
        push = p; push_data = d; pop = q; flush = f; clr_err = c;
        if (f) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            pa = (p && mcount < DEPTH) ? 1 : 0;
            qa = (q && mcount > 0) ? 1 : 0;
            if (pa == 1) exp_q.push_back(d);
            mcount = mcount + pa - qa;
        end
        $display("cyc  push=%0b data=%h pop=%0b flush=%0b clr_err=%0b", p, d, q, f, c);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset(input logic p);
        rst = 1'b1; push = p; push_data = 16'hBEEF;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0;
        exp_q.delete();
        mcount = 0;
        $display("rst  applied");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"}, 32'(count), 32'd0);
        chk({tag, " empty"}, 32'(empty), 32'd1);
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, " full"}, 32'(full), 32'd0);
        chk({tag, " almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, " overflow"}, 32'(overflow), 32'd0);
        chk({tag, " underflow"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        do_reset(1'b0);
        do_reset(1'b0);
        cyc(1'b0, '0, 1'b0);
        chk_reset_vals("reset");

        // Fill: AE drops after 3rd push, AF rises after 6th, full after 8th.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 16'h1000 + 16'(i), 1'b0);
            chk("fill count", 32'(count), 32'(i + 1));
            chk("fill almost_empty", 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            chk("fill almost_full", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk("fill full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
            chk("fill empty", 32'(empty), 32'd0);
        end
        cyc(1'b1, 16'hDEAD, 1'b0);
        chk("overfill count", 32'(count), 32'd8);
        chk("overfill overflow", 32'(overflow), 32'd1);

        // Drain in order.
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);
        chk("drain empty", 32'(empty), 32'd1);
        chk("drain count", 32'(count), 32'd0);
        chk("drain overflow sticky", 32'(overflow), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b0);
        chk("wrap count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
        chk("wrap empty", 32'(empty), 32'd1);

        // Sustained push+pop at count=3.
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h4000 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'h4003 + 16'(i), 1'b1);
            chk("steady count", 32'(count), 32'd3);
        end

        // Push+pop at full.
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b0);
        chk("full before", 32'(full), 32'd1);
        chk("overflow before", 32'(overflow), 32'd0);
        cyc(1'b1, 16'h5FFF, 1'b1);
        chk("full pp count", 32'(count), 32'd7);
        chk("full pp overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1);
        chk("full pp drain empty", 32'(empty), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Push+pop at empty: no fall-through.
        cyc(1'b1, 16'h6000, 1'b1);
        chk("empty pp count", 32'(count), 32'd1);
        chk("empty pp underflow", 32'(underflow), 32'd1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr underflow", 32'(underflow), 32'd0);

        // Flush with push and pop at count=5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h7000 + 16'(i), 1'b0);
        chk("preflush count", 32'(count), 32'd5);
        cyc(1'b1, 16'h7777, 1'b1, 1'b1);
        chk("flush count", 32'(count), 32'd0);
        chk("flush empty", 32'(empty), 32'd1);
        chk("flush overflow", 32'(overflow), 32'd0);
        chk("flush underflow", 32'(underflow), 32'd0);
        cyc(1'b1, 16'h3333, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("post flush empty", 32'(empty), 32'd1);

        // Error clear and set-wins-over-clear.
        cyc(1'b0, '0, 1'b1);
        chk("underflow set", 32'(underflow), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("underflow cleared", 32'(underflow), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("underflow set wins", 32'(underflow), 32'd1);

        // Reset mid-fill.
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h8000 + 16'(i), 1'b0);
        chk("prereset count", 32'(count), 32'd4);
        do_reset(1'b1);
        chk_reset_vals("midreset");

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
